imm_encoder: RTL and testbench

Sequential immediate encoder: the inverse of the processor's `extend` unit. Takes a 32-bit constant and an immediate-format select, and produces the N-bit instruction immediate field that `extend` expands back to that constant, plus a fits flag. Sits in the assembler/test-vector path and in the branch-target patch logic. Uses a valid/ready handshake on input and output, and optionally runs an iterative rotated-immediate search.

---
 rtl/imm_pkg.sv | 20 ++
 rtl/rot_check.sv | 20 ++
 rtl/imm_encoder.sv | 139 +++++++++++++
 tb/tb_imm_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and constants for the immediate encoder
package imm_pkg;

    typedef enum logic [1:0] {
        IMM8  = 2'b00,
        IMM12 = 2'b01,
        BR24  = 2'b10,
        ROT8  = 2'b11
    } imm_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } imm_state_t;

    localparam int         ROT_STEPS = 16;
    localparam logic [3:0] RC_LAST   = 4'(ROT_STEPS - 1);

endpackage

// File: rtl/rot_check.sv
// rtl/rot_check.sv - one rotated-immediate probe: value rol 2*rc, hit when the result fits in 8 bits
module rot_check (
    input  logic [31:0] value,
    input  logic [3:0]  rc,
    output logic        hit,
    output logic [7:0]  imm8
);

    logic [5:0]  w_sh;
    logic [63:0] w_dbl;
    logic [31:0] w_t;

    // Upper half of {v,v} << sh is v rotated left by sh, with no special case at sh = 0.
    assign w_sh  = {1'b0, rc, 1'b0};
    assign w_dbl = {value, value} << w_sh;
    assign w_t   = w_dbl[63:32];
    assign hit   = (w_t[31:8] == 24'd0);
    assign imm8  = w_t[7:0];

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - inverse of extend: constant + format -> immediate field and fits flag (option ROT_IMM_EN)
import imm_pkg::*;

module imm_encoder #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  value,
    input  logic [1:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] field,
    output logic         fits
);

    imm_state_t  r_state;
    imm_state_t  w_next;
    logic [31:0] r_value;
    imm_sel_t    r_sel;
    logic [N-1:0] r_field;
    logic        r_fits;
    logic        r_out_valid;

    logic        w_accept;
    logic        w_stay;
    logic        w_fits;
    logic [N-1:0] w_field_raw;
    logic [N-1:0] w_field;

`ifdef ROT_IMM_EN
    logic [3:0]  r_rc;
    logic        w_rot_hit;
    logic [7:0]  w_rot_imm8;

    rot_check u_rot_check (
        .value (r_value),
        .rc    (r_rc),
        .hit   (w_rot_hit),
        .imm8  (w_rot_imm8)
    );

    assign w_stay = (r_sel == ROT8) && !w_rot_hit && (r_rc != RC_LAST);
`else
    assign w_stay = 1'b0;
`endif

    assign w_accept = in_valid && (r_state == IDLE);

    always_comb begin
        w_fits      = 1'b0;
        w_field_raw = '0;
        case (r_sel)
            IMM8: begin
                w_fits           = (r_value[31:8] == 24'd0);
                w_field_raw[7:0] = r_value[7:0];
            end
            IMM12: begin
                w_fits            = (r_value[31:12] == 20'd0);
                w_field_raw[11:0] = r_value[11:0];
            end
            BR24: begin
                w_fits            = (r_value[1:0] == 2'b00) &&
                                    (r_value[31:26] == {6{r_value[25]}});
                w_field_raw[23:0] = r_value[25:2];
            end
            ROT8: begin
`ifdef ROT_IMM_EN
                w_fits            = w_rot_hit;
                w_field_raw[11:0] = {r_rc, w_rot_imm8};
`endif
            end
            default: begin
                w_fits = 1'b0;
            end
        endcase
        w_field = w_fits ? w_field_raw : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)   w_next = CHECK;
            CHECK:   if (!w_stay)    w_next = DONE;
            DONE:    if (out_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value     <= 32'd0;
            r_sel       <= IMM8;
            r_field     <= '0;
            r_fits      <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef ROT_IMM_EN
            r_rc        <= 4'd0;
`endif
        end else begin
            if (w_accept) begin
                r_value <= value;
                r_sel   <= imm_sel_t'(sel);
`ifdef ROT_IMM_EN
                r_rc    <= 4'd0;
`endif
            end
            if (r_state == CHECK) begin
                if (w_stay) begin
`ifdef ROT_IMM_EN
                    r_rc <= r_rc + 4'd1;
`endif
                end else begin
                    r_field     <= w_field;
                    r_fits      <= w_fits;
                    r_out_valid <= 1'b1;
                end
            end
            if ((r_state == DONE) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = r_out_valid;
        field     = r_field;
        fits      = r_fits;
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed vector bench for imm_encoder (both ROT_IMM_EN builds)
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] field;
    logic        fits;

    int n_pass  = 0;
    int n_total = 0;

    imm_encoder #(.N(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .field     (field),
        .fits      (fits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [1:0]  sel;
        logic [23:0] field;
        logic        fits;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Independent model of extend: field + format -> constant
    function automatic logic [31:0] extend_model(input logic [23:0] f, input logic [1:0] s);
        logic [31:0] w;
        logic [5:0]  sh;
        case (s)
            2'b00:   return {24'd0, f[7:0]};
            2'b01:   return {20'd0, f[11:0]};
            2'b10:   return {{6{f[23]}}, f[23:0], 2'b00};
            default: begin
                w  = {24'd0, f[7:0]};
                sh = {1'b0, f[11:8], 1'b0};
                return (w >> sh) | (w << (6'd32 - sh));
            end
        endcase
    endfunction

    // Issue one request, return measured latency (edges from acceptance to out_valid), or -1 on timeout
    task automatic issue(input logic [31:0] v, input logic [1:0] s, output int lat);
        @(negedge clk);
        value    = v;
        sel      = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        value    = 32'hDEAD_BEEF;
        sel      = 2'b11;
        lat      = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    int   lat;
    logic [23:0] hold_field;
    logic        hold_fits;
    logic        stable;
    logic        ever_valid;

    initial begin
        vecs.push_back('{32'h0000009A, 2'b00, 24'h00009A, 1'b1, 1});
        vecs.push_back('{32'h0000019A, 2'b00, 24'h000000, 1'b0, 1});
        vecs.push_back('{32'h000000FF, 2'b00, 24'h0000FF, 1'b1, 1});
        vecs.push_back('{32'h00000100, 2'b00, 24'h000000, 1'b0, 1});
        vecs.push_back('{32'h0000089A, 2'b01, 24'h00089A, 1'b1, 1});
        vecs.push_back('{32'h00001000, 2'b01, 24'h000000, 1'b0, 1});
        vecs.push_back('{32'hFFA86268, 2'b10, 24'hEA189A, 1'b1, 1});
        vecs.push_back('{32'hFFA86269, 2'b10, 24'h000000, 1'b0, 1});
        vecs.push_back('{32'h7E000000, 2'b10, 24'h000000, 1'b0, 1});
        vecs.push_back('{32'hFE000000, 2'b10, 24'h800000, 1'b1, 1});
`ifdef ROT_IMM_EN
        vecs.push_back('{32'hFF000000, 2'b11, 24'h0004FF, 1'b1, 5});
        vecs.push_back('{32'h00000101, 2'b11, 24'h000000, 1'b0, 16});
        vecs.push_back('{32'h00000000, 2'b11, 24'h000000, 1'b1, 1});
        vecs.push_back('{32'h000000AB, 2'b11, 24'h0000AB, 1'b1, 1});
        vecs.push_back('{32'hC000003F, 2'b11, 24'h0001FF, 1'b1, 2});
`else
        vecs.push_back('{32'hFF000000, 2'b11, 24'h000000, 1'b0, 1});
        vecs.push_back('{32'h00000000, 2'b11, 24'h000000, 1'b0, 1});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        value     = 32'd0;
        sel       = 2'b00;
        out_ready = 1'b1;
        #12;
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_fits",      {31'd0, fits},      32'd0);
        chk("reset_field",     {8'd0, field},      32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            issue(vecs[k].value, vecs[k].sel, lat);
            chk($sformatf("v%0d_latency", k), lat, vecs[k].lat);
            chk($sformatf("v%0d_fits", k), {31'd0, fits}, {31'd0, vecs[k].fits});
            chk($sformatf("v%0d_field", k), {8'd0, field}, {8'd0, vecs[k].field});
            if (vecs[k].fits)
                chk($sformatf("v%0d_extend", k), extend_model(field, vecs[k].sel), vecs[k].value);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_idle_after", k), {30'd0, in_ready, out_valid}, 32'd2);
        end

        // Backpressure: DONE holds with constant outputs; inputs during DONE are ignored
        out_ready = 1'b0;
        issue(32'h0000089A, 2'b01, lat);
        chk("bp_latency", lat, 1);
        hold_field = field;
        hold_fits  = fits;
        stable     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            value    = 32'h12345678;
            sel      = 2'b00;
            if (!out_valid || in_ready || field !== hold_field || fits !== hold_fits) stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_stable", {31'd0, stable}, 32'd1);
        chk("bp_field", {8'd0, hold_field}, 32'h0000089A);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset while holding a result in DONE discards it
        out_ready = 1'b0;
        issue(32'h0000009A, 2'b00, lat);
        chk("rst_done_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_done_abort", {30'd0, in_ready, out_valid}, 32'd2);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;

`ifdef ROT_IMM_EN
        // Reset in the 3rd search cycle of a long ROT8 miss
        @(negedge clk);
        value    = 32'h00000101;
        sel      = 2'b11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_rot_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst        = 1'b0;
        ever_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) ever_valid = 1'b1;
        end
        chk("rst_rot_no_result", {31'd0, ever_valid}, 32'd0);
        chk("rst_rot_idle", {31'd0, in_ready}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
